// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serializing Arduino and core requests onto one memory port.
// Each access runs IDLE -> ISSUE -> (WAIT -> RESP for reads). All outputs are registered.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned MEM_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_we,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [2:0]      LAT   = 3'(RD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic              win_c;
    logic              last_c;
    logic              owner_c;
    logic              lat_we;
    logic              lat_inr;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_inr;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        // On a tie the requester that did not own the port last time wins
        win_c     = c_req && (!a_req || !last_c);
        sel_addr  = win_c ? c_addr  : a_addr;
        sel_we    = win_c ? c_we    : a_we;
        sel_wdata = win_c ? c_wdata : a_wdata;
        sel_inr   = {1'b0, sel_addr} < LIMIT;
        rd_word   = lat_inr ? mem_rdata : '0;
        state_nxt = state;
        case (state)
            S_IDLE:  if (a_req || c_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = lat_we ? S_IDLE : S_WAIT;
            S_WAIT:  if (cnt == LAT) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_gnt     <= 1'b0;
            c_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            c_rvalid  <= 1'b0;
            a_rdata   <= '0;
            c_rdata   <= '0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            last_c    <= 1'b1;
            owner_c   <= 1'b0;
            lat_we    <= 1'b0;
            lat_inr   <= 1'b0;
            cnt       <= '0;
        end else begin
            a_gnt    <= 1'b0;
            c_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            c_rvalid <= 1'b0;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                S_IDLE: if (a_req || c_req) begin
                    // Issue-cycle outputs are loaded here so they appear in ISSUE
                    owner_c   <= win_c;
                    lat_we    <= sel_we;
                    lat_inr   <= sel_inr;
                    a_gnt     <= !win_c;
                    c_gnt     <= win_c;
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_wdata;
                    mem_we    <= sel_we && sel_inr;
                    err       <= sel_we && !sel_inr;
                    busy      <= 1'b1;
                end
                S_ISSUE: begin
                    last_c <= owner_c;
                    cnt    <= 3'd1;
                    if (lat_we) busy <= 1'b0;
                end
                S_WAIT: begin
                    if (cnt == LAT) begin
                        if (owner_c) begin
                            c_rvalid <= 1'b1;
                            c_rdata  <= rd_word;
                        end else begin
                            a_rvalid <= 1'b1;
                            a_rdata  <= rd_word;
                        end
                        err <= !lat_inr;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_RESP: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default instance plus one with MEM_WORDS=1000
// sharing the same stimulus, used for out-of-range checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, c_req, a_we, c_we;
    logic [19:0] a_addr, c_addr;
    logic [7:0]  a_wdata, c_wdata, mem_rdata;

    logic        a_gnt, a_rvalid, c_gnt, c_rvalid, err, mem_we, busy;
    logic [7:0]  a_rdata, c_rdata, mem_wdata;
    logic [19:0] mem_addr;

    logic        o_a_gnt, o_a_rvalid, o_c_gnt, o_c_rvalid, o_err, o_mem_we, o_busy;
    logic [7:0]  o_a_rdata, o_c_rdata, o_mem_wdata;
    logic [19:0] o_mem_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(20), .DATA_W(8), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .c_req(c_req), .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .err(err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(20), .DATA_W(8), .RD_LAT(2), .MEM_WORDS(1000)) dut_oor (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_gnt(o_a_gnt), .a_rvalid(o_a_rvalid), .a_rdata(o_a_rdata),
        .c_req(c_req), .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata),
        .c_gnt(o_c_gnt), .c_rvalid(o_c_rvalid), .c_rdata(o_c_rdata),
        .err(o_err), .mem_addr(o_mem_addr), .mem_we(o_mem_we), .mem_wdata(o_mem_wdata),
        .mem_rdata(mem_rdata), .busy(o_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; c_req = 1'b0; a_we = 1'b0; c_we = 1'b0;
        a_addr = '0; c_addr = '0; a_wdata = '0; c_wdata = '0;
        mem_rdata = 8'hEE;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (busy === 1'b0) done = 1'b1;
            else step();
        end
        checks++; if (!done) begin failures++; $display("FAIL %s_drain busy=%b required 0 within 12 cycles", name, busy); end
    endtask

    task automatic test_reset();
        logic [50:0] outs;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_req = 1'($urandom_range(0, 1)); c_req = 1'($urandom_range(0, 1));
            a_we = 1'($urandom_range(0, 1));  c_we = 1'($urandom_range(0, 1));
            a_addr = 20'($urandom); c_addr = 20'($urandom);
            a_wdata = 8'($urandom); c_wdata = 8'($urandom); mem_rdata = 8'($urandom);
            step();
            outs = {a_gnt, a_rvalid, a_rdata, c_gnt, c_rvalid, c_rdata, err, mem_addr, mem_we, mem_wdata, busy};
            checks++; if (outs !== 51'd0) begin failures++; $display("FAIL reset_during got=%h required=0", outs); end
        end
        idle_inputs();
        rst = 1'b0;
        step();
        outs = {a_gnt, a_rvalid, a_rdata, c_gnt, c_rvalid, c_rdata, err, mem_addr, mem_we, mem_wdata, busy};
        checks++; if (outs !== 51'd0) begin failures++; $display("FAIL reset_after got=%h required=0", outs); end
    endtask

    task automatic test_a_read();
        a_req = 1'b1; a_addr = 20'h00010; a_we = 1'b0;
        step();  // t+1
        checks++; if ({a_gnt, c_gnt} !== 2'b10) begin failures++; $display("FAIL rd_gnt a/c got=%b required=10", {a_gnt, c_gnt}); end
        checks++; if (mem_addr !== 20'h00010) begin failures++; $display("FAIL rd_mem_addr got=%h required=00010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%b required=0", mem_we); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy got=%b required=1", busy); end
        a_req = 1'b0;
        step();  // t+2
        checks++; if ({a_rvalid, c_rvalid} !== 2'b00) begin failures++; $display("FAIL rd_early_rvalid t+2 got=%b required=00", {a_rvalid, c_rvalid}); end
        step();  // t+3
        mem_rdata = 8'hA5;
        checks++; if ({a_rvalid, c_rvalid} !== 2'b00) begin failures++; $display("FAIL rd_early_rvalid t+3 got=%b required=00", {a_rvalid, c_rvalid}); end
        step();  // t+4
        mem_rdata = 8'hEE;
        checks++; if ({a_rvalid, c_rvalid} !== 2'b10) begin failures++; $display("FAIL rd_rvalid a/c got=%b required=10", {a_rvalid, c_rvalid}); end
        checks++; if (a_rdata !== 8'hA5) begin failures++; $display("FAIL rd_a_rdata got=%h required=a5", a_rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b required=0", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy_resp got=%b required=1", busy); end
        step();  // t+5
        checks++; if ({busy, a_rvalid} !== 2'b00) begin failures++; $display("FAIL rd_end busy/rvalid got=%b required=00", {busy, a_rvalid}); end
        checks++; if (a_rdata !== 8'hA5) begin failures++; $display("FAIL rd_a_rdata_hold got=%h required=a5", a_rdata); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_v, got_v;
        bit         slot, own_c;
        rst = 1'b1;
        a_req = 1'b1; a_addr = 20'h00020; a_we = 1'b0;
        c_req = 1'b1; c_addr = 20'h00030; c_we = 1'b0;
        mem_rdata = 8'h5A;
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            slot  = (i % 5 == 0);
            own_c = ((i / 5) % 2 == 1);
            exp_v = {slot && !own_c, slot && own_c, (i % 5 == 3) && !own_c, (i % 5 == 3) && own_c};
            got_v = {a_gnt, c_gnt, a_rvalid, c_rvalid};
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL rr_cycle%0d gnt_a,gnt_c,rv_a,rv_c got=%b required=%b", i, got_v, exp_v); end
            if (slot) begin
                checks++; if (mem_addr !== (own_c ? 20'h00030 : 20'h00020)) begin failures++; $display("FAIL rr_addr cycle%0d got=%h required=%h", i, mem_addr, own_c ? 20'h00030 : 20'h00020); end
            end
            step();
        end
        checks++; if ({a_rdata, c_rdata} !== 16'h5A5A) begin failures++; $display("FAIL rr_rdata got=%h required=5a5a", {a_rdata, c_rdata}); end
        idle_inputs();
        wait_idle("rr");
    endtask

    task automatic test_c_write();
        c_req = 1'b1; c_addr = 20'hFFFFF; c_we = 1'b1; c_wdata = 8'h3C;
        step();  // t+1
        checks++; if ({c_gnt, a_gnt} !== 2'b10) begin failures++; $display("FAIL wr_gnt c/a got=%b required=10", {c_gnt, a_gnt}); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL wr_mem_we got=%b required=1", mem_we); end
        checks++; if (mem_addr !== 20'hFFFFF) begin failures++; $display("FAIL wr_mem_addr got=%h required=fffff", mem_addr); end
        checks++; if (mem_wdata !== 8'h3C) begin failures++; $display("FAIL wr_mem_wdata got=%h required=3c", mem_wdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b required=0", err); end
        c_req = 1'b0; c_we = 1'b0;
        step();  // t+2
        checks++; if ({busy, mem_we} !== 2'b00) begin failures++; $display("FAIL wr_done busy/mem_we got=%b required=00", {busy, mem_we}); end
        checks++; if (mem_addr !== 20'hFFFFF) begin failures++; $display("FAIL wr_addr_hold got=%h required=fffff", mem_addr); end
        for (int i = 0; i < 3; i++) begin
            checks++; if ({a_rvalid, c_rvalid} !== 2'b00) begin failures++; $display("FAIL wr_no_rvalid got=%b required=00", {a_rvalid, c_rvalid}); end
            step();
        end
    endtask

    task automatic test_out_of_range();
        // Boundary: 999 is the last valid word
        a_req = 1'b1; a_addr = 20'd999; a_we = 1'b1; a_wdata = 8'h11;
        step();
        checks++; if ({o_a_gnt, o_mem_we, o_err} !== 3'b110) begin failures++; $display("FAIL oor_999 gnt/we/err got=%b required=110", {o_a_gnt, o_mem_we, o_err}); end
        a_req = 1'b0;
        step();
        a_req = 1'b1; a_addr = 20'd1000; a_we = 1'b1; a_wdata = 8'h77;
        step();
        checks++; if ({o_a_gnt, o_mem_we, o_err} !== 3'b101) begin failures++; $display("FAIL oor_wr gnt/we/err got=%b required=101", {o_a_gnt, o_mem_we, o_err}); end
        checks++; if ({mem_we, err} !== 2'b10) begin failures++; $display("FAIL oor_wr_default we/err got=%b required=10", {mem_we, err}); end
        a_req = 1'b0; a_we = 1'b0;
        step();
        checks++; if ({o_err, o_mem_we, o_busy} !== 3'b000) begin failures++; $display("FAIL oor_wr_after err/we/busy got=%b required=000", {o_err, o_mem_we, o_busy}); end
        a_req = 1'b1; a_addr = 20'd1000; a_we = 1'b0;
        step();  // t+1
        checks++; if ({o_a_gnt, o_err} !== 2'b10) begin failures++; $display("FAIL oor_rd_gnt gnt/err got=%b required=10", {o_a_gnt, o_err}); end
        a_req = 1'b0;
        step();  // t+2
        step();  // t+3
        mem_rdata = 8'hA5;
        step();  // t+4
        mem_rdata = 8'hEE;
        checks++; if ({o_a_rvalid, o_err} !== 2'b11) begin failures++; $display("FAIL oor_rd_resp rvalid/err got=%b required=11", {o_a_rvalid, o_err}); end
        checks++; if (o_a_rdata !== 8'h00) begin failures++; $display("FAIL oor_rd_rdata got=%h required=00", o_a_rdata); end
        checks++; if ({a_rvalid, err, a_rdata} !== 10'b10_1010_0101) begin failures++; $display("FAIL oor_rd_default rvalid/err/rdata got=%b required=1010100101", {a_rvalid, err, a_rdata}); end
        step();
        checks++; if ({o_err, o_a_rvalid} !== 2'b00) begin failures++; $display("FAIL oor_rd_after err/rvalid got=%b required=00", {o_err, o_a_rvalid}); end
    endtask

    task automatic test_reset_mid_read();
        a_req = 1'b1; a_addr = 20'h00040; a_we = 1'b0;
        step();  // ISSUE
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b required=1", a_gnt); end
        a_req = 1'b0;
        step();  // first WAIT cycle
        rst = 1'b1;
        mem_rdata = 8'hC3;
        step();
        rst = 1'b0;
        checks++; if ({busy, a_rdata, c_rdata} !== 17'd0) begin failures++; $display("FAIL mid_reset busy/rdata got=%h required=0", {busy, a_rdata, c_rdata}); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({a_rvalid, c_rvalid} !== 2'b00) begin failures++; $display("FAIL mid_no_rvalid cycle%0d got=%b required=00", i, {a_rvalid, c_rvalid}); end
            step();
        end
        mem_rdata = 8'hEE;
        a_req = 1'b1; c_req = 1'b1; a_addr = 20'h00050; c_addr = 20'h00060;
        step();
        checks++; if ({a_gnt, c_gnt} !== 2'b10) begin failures++; $display("FAIL mid_tie a/c got=%b required=10", {a_gnt, c_gnt}); end
        idle_inputs();
        wait_idle("mid");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_a_read();
        test_round_robin();
        test_c_write();
        test_out_of_range();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester, round-robin arbiter for the single shared memory port. The registered 20-bit Arduino address/command path and the internal processing core each present requests, and the block serializes them onto one memory port. It sequences each access through issue, wait and response phases. It also handles the fixed memory read latency and returns read data to the owning requester. It suppresses out-of-range accesses.

## Interface
- ADDR_W, 20, address width (matches the Arduino address register)
- DATA_W, 8, data word width
- RD_LAT, 2, memory read latency in cycles from the issue cycle to valid mem_rdata; legal range 1..4
- MEM_WORDS, 2**ADDR_W, number of valid words; addresses >= MEM_WORDS are out of range
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  Arduino request; held high with a_addr/a_we/a_wdata stable until a_gnt is seen
- a_addr  in  ADDR_W  Arduino address
- a_we  in  1  1 = write, 0 = read
- a_wdata  in  DATA_W  Arduino write data
- a_gnt  out  1  one-cycle pulse: Arduino request accepted
- a_rvalid  out  1  one-cycle pulse: a_rdata valid (reads only)
- a_rdata  out  DATA_W  read data to Arduino
- c_req, c_addr, c_we, c_wdata, c_gnt, c_rvalid, c_rdata  same meaning, for the core requester
- err  out  1  one-cycle pulse with gnt (writes) or rvalid (reads) of an out-of-range access
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the issue cycle
- busy  out  1  high in every state except IDLE

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample a_req and c_req.
  - If neither is high, stay in IDLE.
  - If exactly one is high, it wins.
  - If both are high, the requester that is not last_owner wins.
  - Latch the winner's addr/we/wdata and the owner id, then go to ISSUE.
- ISSUE (1 cycle):
  - Assert the winner's gnt and drive mem_addr/mem_wdata from the latched values.
  - mem_we = latched we AND in-range.
  - Update last_owner to the winner.
  - A write goes next to IDLE; a read goes to WAIT.
- WAIT: count RD_LAT cycles from ISSUE. In the cycle where mem_rdata is valid, register it (or 0 if out of range), then go to RESP.
- RESP (1 cycle): pulse the owner's rvalid; the owner's rdata holds the registered value. err pulses if out of range. Go to IDLE.
- Per-requester rdata holds its last value until the next response to that requester.
- Out-of-range access (addr >= MEM_WORDS): a write is never strobed and err pulses with gnt; a read returns 0 and err pulses with rvalid.
- Requesters must drop req in the cycle after gnt or present a new request. The arbiter ignores req outside IDLE, so a held req is simply re-arbitrated in the next IDLE.

## Timing
- All outputs are registered.
- Reset values: all gnt/rvalid/err = 0; rdata = 0; mem_addr = 0; mem_we = 0; mem_wdata = 0; busy = 0; state = IDLE; last_owner = core, so the Arduino wins the first tie.
- A request sampled in IDLE at cycle t gives gnt and mem signals at t+1.
- For a read, mem_rdata is valid at t+1+RD_LAT and rvalid pulses at t+2+RD_LAT.
- After rvalid, state is IDLE at t+3+RD_LAT.
- Write occupancy is 2 cycles (IDLE, ISSUE); read occupancy is RD_LAT+3 cycles.
- mem_we is high only in ISSUE. mem_addr/mem_wdata hold their last values otherwise.
- Reset takes priority over everything.
  - Reset in WAIT or RESP drops the pending read with no rvalid.
  - The next cycle is IDLE with reset values.

## Test plan
- Reset: assert rst 2 cycles with random inputs → all outputs 0 and busy 0 during and after the reset cycle.
- Arduino read, RD_LAT=2:
  - Stimulus: a_req, a_addr=0x00010 at t; memory model returns 0xA5 at t+3.
  - Required: a_gnt and mem_addr=0x00010 at t+1 with mem_we=0; a_rvalid and a_rdata=0xA5 at t+4; c_rvalid stays 0.
- Tie round-robin: a_req and c_req both held high continuously from reset, all reads → grant order A, C, A, C; each gnt is preceded by a full read sequence of the previous owner.
- Core write:
  - Stimulus: c_addr=0xFFFFF, c_we=1, c_wdata=0x3C.
  - Required: at t+1, c_gnt=1, mem_we=1, mem_addr=0xFFFFF, mem_wdata=0x3C; no rvalid; busy=0 at t+2.
- Out of range, MEM_WORDS=1000:
  - Write to addr 1000 → mem_we stays 0; err and gnt at t+1.
  - Read from addr 1000 → rdata=0x00; err and rvalid at t+4.
- Reset mid-read: assert rst in the first WAIT cycle → no rvalid ever; busy=0 next cycle; a subsequent tie grants the Arduino.
